// File: rtl/uart_rx_gen.sv
// UART receiver: runtime data length, five parity modes, 1/2 stop bits,
// 3-sample majority vote at bit centre, one-entry valid/ready output register.
module uart_rx_gen #(
  parameter int unsigned MaxDataW   = 9,
  parameter int unsigned Oversample = 16,
  parameter int unsigned CntW       = $clog2(Oversample)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                tick_i,
  input  logic                rx_i,
  input  logic [3:0]          data_len_i,
  input  logic [2:0]          parity_mode_i,
  input  logic                stop2_i,
  output logic [MaxDataW-1:0] rdata_o,
  output logic                rvalid_o,
  input  logic                rready_i,
  output logic                frame_err_o,
  output logic                parity_err_o,
  output logic                break_o,
  output logic                overflow_o,
  output logic                idle_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT_HIGH
  } state_e;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } par_e;

  localparam logic [CntW-1:0] CntS0   = CntW'(Oversample / 2 - 1);
  localparam logic [CntW-1:0] CntS1   = CntW'(Oversample / 2);
  localparam logic [CntW-1:0] CntS2   = CntW'(Oversample / 2 + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(Oversample - 1);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q;
  logic [3:0]          bit_q;
  logic [3:0]          len_q, len_in;
  par_e                par_q, par_in;
  logic                stop2_q;
  logic [1:0]          smp_q;
  logic [MaxDataW-1:0] shreg_q;
  logic                frame_q, perr_q, pbit_q;

  logic step, at_dec, at_last, maj, done, frame_fin, exp_par, load, brk;

  // Config sanitising: clamp length, fold unknown parity modes to none.
  always_comb begin
    len_in = data_len_i;
    if (data_len_i < 4'd5) len_in = 4'd5;
    else if (32'(data_len_i) > MaxDataW) len_in = 4'(MaxDataW);
    par_in = PAR_NONE;
    if (parity_mode_i <= 3'd4) par_in = par_e'(parity_mode_i);
  end

  always_comb begin
    step      = enable_i & tick_i;
    at_dec    = step && (cnt_q == CntS2);
    at_last   = step && (cnt_q == CntLast);
    maj       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_i) | (smp_q[1] & rx_i);
    frame_fin = frame_q | ~maj;
    case (par_q)
      PAR_EVEN: exp_par = ^shreg_q;
      PAR_ODD:  exp_par = ~^shreg_q;
      PAR_MARK: exp_par = 1'b1;
      default:  exp_par = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE:   if (step && !rx_i) state_d = S_START;
      S_START: begin
        if (at_dec && maj) state_d = S_IDLE;
        else if (at_last)  state_d = S_DATA;
      end
      S_DATA: begin
        if (at_last && (bit_q == len_q - 4'd1))
          state_d = (par_q == PAR_NONE) ? S_STOP1 : S_PARITY;
      end
      S_PARITY: if (at_last) state_d = S_STOP1;
      S_STOP1: begin
        if (at_dec && !stop2_q) begin
          done    = 1'b1;
          state_d = frame_fin ? S_WAIT_HIGH : S_IDLE;
        end else if (at_last) begin
          state_d = S_STOP2;
        end
      end
      S_STOP2: begin
        if (at_dec) begin
          done    = 1'b1;
          state_d = frame_fin ? S_WAIT_HIGH : S_IDLE;
        end
      end
      S_WAIT_HIGH: if (step && rx_i) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (!enable_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      len_q   <= '0;
      par_q   <= PAR_NONE;
      stop2_q <= 1'b0;
      smp_q   <= '0;
      shreg_q <= '0;
      frame_q <= 1'b0;
      perr_q  <= 1'b0;
      pbit_q  <= 1'b0;
    end else if (!enable_i) begin
      cnt_q <= '0;
      bit_q <= '0;
    end else if (tick_i) begin
      if (state_q == S_IDLE)
        cnt_q <= (state_d == S_START) ? CntW'(1) : '0;
      else if (state_q == S_WAIT_HIGH || state_d == S_IDLE || state_d == S_WAIT_HIGH)
        cnt_q <= '0;
      else if (cnt_q == CntLast)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + CntW'(1);

      if (cnt_q == CntS0) smp_q[0] <= rx_i;
      if (cnt_q == CntS1) smp_q[1] <= rx_i;

      if (state_q == S_IDLE && state_d == S_START) begin
        len_q   <= len_in;
        par_q   <= par_in;
        stop2_q <= stop2_i;
        shreg_q <= '0;
        bit_q   <= '0;
        frame_q <= 1'b0;
        perr_q  <= 1'b0;
        pbit_q  <= 1'b0;
      end

      case (state_q)
        S_DATA: begin
          if (cnt_q == CntS2) begin
            for (int unsigned i = 0; i < MaxDataW; i++)
              if (32'(bit_q) == i) shreg_q[i] <= maj;
          end
          if (cnt_q == CntLast) bit_q <= bit_q + 4'd1;
        end
        S_PARITY: begin
          if (cnt_q == CntS2) begin
            pbit_q <= maj;
            perr_q <= maj ^ exp_par;
          end
        end
        S_STOP1: if (cnt_q == CntS2) frame_q <= frame_q | ~maj;
        default: ;
      endcase
    end
  end

  // A completing character may replace the held one when it is being accepted
  // in the same cycle; otherwise it is dropped and flagged as overflow.
  always_comb begin
    load = done & (~rvalid_o | rready_i);
    brk  = frame_fin & (shreg_q == '0) & ((par_q == PAR_NONE) | ~pbit_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_o      <= '0;
      rvalid_o     <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      break_o      <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      overflow_o <= done & ~load;
      if (load) begin
        rdata_o      <= shreg_q;
        frame_err_o  <= frame_fin;
        parity_err_o <= perr_q;
        break_o      <= brk;
        rvalid_o     <= 1'b1;
      end else if (rvalid_o && rready_i) begin
        rvalid_o <= 1'b0;
      end
    end
  end

  assign idle_o = (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_rx_gen.sv
// Scoreboard bench for uart_rx_gen: frames are built bit by bit, expected
// characters are queued at send time and compared on each accepted output.
module tb_uart_rx_gen;

  localparam int unsigned MaxDataW   = 9;
  localparam int unsigned Oversample = 16;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                enable_i = 1'b1;
  logic                tick_i = 1'b1;
  logic                rx_i = 1'b1;
  logic [3:0]          data_len_i = 4'd8;
  logic [2:0]          parity_mode_i = 3'd0;
  logic                stop2_i = 1'b0;
  logic [MaxDataW-1:0] rdata_o;
  logic                rvalid_o;
  logic                rready_i = 1'b1;
  logic                frame_err_o, parity_err_o, break_o, overflow_o, idle_o;

  uart_rx_gen #(.MaxDataW(MaxDataW), .Oversample(Oversample)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .tick_i(tick_i),
    .rx_i(rx_i), .data_len_i(data_len_i), .parity_mode_i(parity_mode_i),
    .stop2_i(stop2_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .rready_i(rready_i), .frame_err_o(frame_err_o), .parity_err_o(parity_err_o),
    .break_o(break_o), .overflow_o(overflow_o), .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [8:0] d;
    logic       fe;
    logic       pe;
    logic       br;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ovf_cnt = 0;
  int div = 1;
  int tph = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk_i) cyc++;

  // Tick divider: tick_i high one cycle in every div.
  always @(posedge clk_i) begin
    #1;
    tph = (tph + 1 >= div) ? 0 : tph + 1;
    tick_i = (tph == 0);
  end

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (overflow_o) ovf_cnt++;
      if (rvalid_o && rready_i) begin
        if (q.size() == 0) begin
          check("spurious_char", {31'd0, rvalid_o}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("rdata", 32'(rdata_o), 32'(e.d));
          check("frame_err", 32'(frame_err_o), 32'(e.fe));
          check("parity_err", 32'(parity_err_o), 32'(e.pe));
          check("break", 32'(break_o), 32'(e.br));
        end
      end
    end
  end

  task automatic hold_bit(input logic v, input int nbits);
    rx_i = v;
    repeat (nbits * Oversample * div) @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [8:0] d, input int nb, input int has_par,
                            input logic pb, input int nstop);
    hold_bit(1'b0, 1);
    for (int i = 0; i < nb; i++) hold_bit(d[i], 1);
    if (has_par != 0) hold_bit(pb, 1);
    hold_bit(1'b1, nstop);
  endtask

  task automatic push(input logic [8:0] d, input logic fe, input logic pe, input logic br);
    exp_t e;
    e.d = d; e.fe = fe; e.pe = pe; e.br = br;
    q.push_back(e);
  endtask

  task automatic cfg(input logic [3:0] len, input logic [2:0] pm, input logic s2);
    data_len_i = len; parity_mode_i = pm; stop2_i = s2;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk_i);
    check(tag, q.size(), 32'd0);
  endtask

  initial begin
    int c0;
    int lat;
    bit seen;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
    check("rst_rdata", 32'(rdata_o), 32'd0);
    check("rst_idle", {31'd0, idle_o}, 32'd1);
    check("rst_ovf", {31'd0, overflow_o}, 32'd0);
    check("rst_flags", {29'd0, frame_err_o, parity_err_o, break_o}, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // 8N1 0xA5 with completion latency
    cfg(4'd8, 3'd0, 1'b0);
    hold_bit(1'b1, 1);
    push(9'h0A5, 1'b0, 1'b0, 1'b0);
    lat = -1;
    c0 = cyc;
    fork
      send_frame(9'h0A5, 8, 0, 1'b0, 1);
      begin
        for (int i = 0; i < 300; i++) begin
          @(negedge clk_i);
          if (rvalid_o) begin
            lat = cyc - c0;
            check("idle_at_valid", {31'd0, idle_o}, 32'd1);
            break;
          end
        end
      end
    join
    check("latency_8n1", 32'(lat), 32'd154);
    drain("drain_a5");

    // 7E2 with deliberately wrong parity bit
    cfg(4'd7, 3'd1, 1'b1);
    push(9'h035, 1'b0, 1'b1, 1'b0);
    send_frame(9'h035, 7, 1, 1'b1, 2);
    drain("drain_7e2");

    // Short length clamps to 5, odd parity correct
    cfg(4'd3, 3'd2, 1'b0);
    push(9'h013, 1'b0, 1'b0, 1'b0);
    send_frame(9'h013, 5, 1, 1'b0, 1);
    // Long length clamps to MaxDataW, mode 7 behaves as none
    cfg(4'd15, 3'd7, 1'b0);
    push(9'h1A5, 1'b0, 1'b0, 1'b0);
    send_frame(9'h1A5, 9, 0, 1'b0, 1);
    drain("drain_clamp");

    // Break: line low for 20 bit times, then a clean 0x55
    cfg(4'd8, 3'd0, 1'b0);
    push(9'h000, 1'b1, 1'b0, 1'b1);
    hold_bit(1'b0, 20);
    check("break_count", q.size(), 32'd0);
    hold_bit(1'b1, 2);
    push(9'h055, 1'b0, 1'b0, 1'b0);
    send_frame(9'h055, 8, 0, 1'b0, 1);
    drain("drain_break");

    // Overflow: consumer stalled for two characters
    check("ovf_before", 32'(ovf_cnt), 32'd0);
    rready_i = 1'b0;
    push(9'h011, 1'b0, 1'b0, 1'b0);
    send_frame(9'h011, 8, 0, 1'b0, 1);
    send_frame(9'h022, 8, 0, 1'b0, 1);
    hold_bit(1'b1, 1);
    check("ovf_held_valid", {31'd0, rvalid_o}, 32'd1);
    check("ovf_held_data", 32'(rdata_o), 32'h011);
    check("ovf_pulses", 32'(ovf_cnt), 32'd1);
    rready_i = 1'b1;
    drain("drain_ovf");

    // Glitch: 3 ticks low then high
    c0 = cyc;
    rx_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check("glitch_busy", {31'd0, idle_o}, 32'd0);
    @(posedge clk_i);
    @(posedge clk_i); #1;
    rx_i = 1'b1;
    seen = 1'b0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (idle_o) begin seen = 1'b1; lat = cyc - c0; break; end
    end
    check("glitch_idle_seen", {31'd0, seen}, 32'd1);
    check("glitch_idle_time", 32'(lat), 32'd10);
    hold_bit(1'b1, 2);

    // Enable dropped for one cycle mid-DATA
    hold_bit(1'b0, 1);
    hold_bit(1'b1, 1);
    rx_i = 1'b0;
    repeat (8) @(posedge clk_i);
    #1;
    rx_i = 1'b1;
    enable_i = 1'b0;
    @(posedge clk_i); #1;
    enable_i = 1'b1;
    @(negedge clk_i);
    check("abort_idle", {31'd0, idle_o}, 32'd1);
    hold_bit(1'b1, 3);
    push(9'h03C, 1'b0, 1'b0, 1'b0);
    send_frame(9'h03C, 8, 0, 1'b0, 1);
    drain("drain_enable");

    // Sparse ticks: one tick every third cycle
    div = 3;
    hold_bit(1'b1, 1);
    push(9'h096, 1'b0, 1'b0, 1'b0);
    send_frame(9'h096, 8, 0, 1'b0, 1);
    drain("drain_div3");
    div = 1;

    repeat (50) @(posedge clk_i);
    check("ovf_total", 32'(ovf_cnt), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
